// File: rtl/skywater_dlyline_ctrl_pkg.sv
// rtl/skywater_dlyline_ctrl_pkg.sv - shared types and constants for the delay-line controller
package skywater_dlyline_ctrl_pkg;

    localparam int CODE_W    = 7;
    localparam int NCELL_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // One cell toward tgt, never leaving 0..lim.
    function automatic logic [CODE_W-1:0] step_toward(
        input logic [CODE_W-1:0] cur,
        input logic [CODE_W-1:0] tgt,
        input logic [CODE_W-1:0] lim
    );
        logic [CODE_W-1:0] res;
        res = cur;
        if (cur < tgt && cur < lim) begin
            res = cur + 1'b1;
        end else if (cur > tgt && cur != '0) begin
            res = cur - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/skywater_dlyline_therm_enc.sv
// rtl/skywater_dlyline_therm_enc.sv - binary code to thermometer word (bit k set when k < code)
module skywater_dlyline_therm_enc
    import skywater_dlyline_ctrl_pkg::*;
#(
    parameter int NCELL = NCELL_DEF
) (
    input  logic [CODE_W-1:0] code,
    output logic [NCELL-1:0]  therm
);

    // Each cell is enabled when its index lies below the requested count.
    always_comb begin
        therm = '0;
        for (int k = 0; k < NCELL; k++) begin
            therm[k] = (int'(code) > k);
        end
    end

endmodule

// File: rtl/skywater_dlyline_ctrl.sv
// rtl/skywater_dlyline_ctrl.sv - ramps a thermometer-coded delay line one cell at a time with settle gaps
module skywater_dlyline_ctrl
    import skywater_dlyline_ctrl_pkg::*;
#(
    parameter int NCELL  = NCELL_DEF,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_vld,
    output logic              code_rdy,
    output logic [NCELL-1:0]  bk,
    output logic [CODE_W-1:0] cur_code,
    output logic              busy,
    output logic              done
);

    localparam logic [CODE_W-1:0] MAX_CODE    = CODE_W'(NCELL);
    localparam logic [3:0]        SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CODE_W-1:0] target;
    logic [CODE_W-1:0] target_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic [CODE_W-1:0] req_code;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [NCELL-1:0]  therm_nxt;

    // Requests above the line length saturate to all cells enabled.
    assign req_code = (code_in > MAX_CODE) ? MAX_CODE : code_in;

    // The code that will be applied next cycle, encoded here so bk can be registered
    // together with cur_code and never disagree with it.
    skywater_dlyline_therm_enc #(
        .NCELL(NCELL)
    ) u_therm_enc (
        .code (code_nxt),
        .therm(therm_nxt)
    );

    // Next-state logic; a step is taken on every edge that enters STEP.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        code_nxt   = cur_code;
        cnt_nxt    = cnt;
        case (state)
            S_IDLE: begin
                if (code_vld) begin
                    target_nxt = req_code;
                    if (req_code != cur_code) begin
                        state_nxt = S_STEP;
                        code_nxt  = step_toward(cur_code, req_code, MAX_CODE);
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_STEP: begin
                if (SETTLE == 0) begin
                    if (cur_code != target) begin
                        state_nxt = S_STEP;
                        code_nxt  = step_toward(cur_code, target, MAX_CODE);
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt = '0;
                    if (cur_code != target) begin
                        state_nxt = S_STEP;
                        code_nxt  = step_toward(cur_code, target, MAX_CODE);
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and all outputs are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            target   <= '0;
            cnt      <= '0;
            cur_code <= '0;
            bk       <= '0;
            code_rdy <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            cnt      <= cnt_nxt;
            cur_code <= code_nxt;
            bk       <= therm_nxt;
            code_rdy <= (state_nxt == S_IDLE);
            busy     <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_skywater_dlyline_ctrl.sv
// tb/tb_skywater_dlyline_ctrl.sv - randomized self-checking bench for skywater_dlyline_ctrl
module tb_skywater_dlyline_ctrl;

    logic        clk;
    logic        rst_a, rst_b;
    logic [6:0]  code_a, code_b;
    logic        vld_a, vld_b;
    logic        rdy_a, rdy_b;
    logic [63:0] bk_a, bk_b;
    logic [6:0]  cur_a, cur_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;

    int vectors;
    int errors;
    int sel;
    int model_cur [2];

    logic [6:0]  o_cur;
    logic [63:0] o_bk;
    logic        o_rdy, o_busy, o_done;

    skywater_dlyline_ctrl #(.NCELL(64), .SETTLE(3)) dut_a (
        .clk(clk), .rst(rst_a), .code_in(code_a), .code_vld(vld_a), .code_rdy(rdy_a),
        .bk(bk_a), .cur_code(cur_a), .busy(busy_a), .done(done_a)
    );

    skywater_dlyline_ctrl #(.NCELL(64), .SETTLE(0)) dut_b (
        .clk(clk), .rst(rst_b), .code_in(code_b), .code_vld(vld_b), .code_rdy(rdy_b),
        .bk(bk_b), .cur_code(cur_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (sel == 0) begin
            o_cur = cur_a; o_bk = bk_a; o_rdy = rdy_a; o_busy = busy_a; o_done = done_a;
        end else begin
            o_cur = cur_b; o_bk = bk_b; o_rdy = rdy_b; o_busy = busy_b; o_done = done_b;
        end
    end

    task automatic drive(input int code, input logic v);
        if (sel == 0) begin
            code_a = 7'(code); vld_a = v;
        end else begin
            code_b = 7'(code); vld_b = v;
        end
    endtask

    // One request against the model: after acceptance, step k lands at cycle 1+(k-1)*(S+1)
    // and done is high at cycle N*(S+1)+1 (1 for a no-op); ready returns the cycle after.
    task automatic run_req(input int which, input int code, input bit hold, input string tag);
        int s, c, t, n, d, k, exp_cur;
        logic [63:0] exp_bk;
        sel = which;
        #1;
        s = (which == 0) ? 3 : 0;
        c = model_cur[which];
        t = (code > 64) ? 64 : code;
        n = (t > c) ? t - c : c - t;
        d = (n == 0) ? 1 : n * (s + 1) + 1;
        vectors++;
        if (o_rdy !== 1'b1) begin
            errors++; $display("FAIL %s rdy_before got=%b exp=1", tag, o_rdy);
        end
        drive(code, 1'b1);
        @(posedge clk); #1;
        for (int j = 1; j <= d + 1; j++) begin
            k = (j - 1) / (s + 1) + 1;
            if (k > n) k = n;
            exp_cur = (t >= c) ? c + k : c - k;
            exp_bk = (exp_cur >= 64) ? '1 : ((64'd1 << exp_cur) - 64'd1);
            vectors++;
            if (o_cur !== 7'(exp_cur)) begin
                errors++; $display("FAIL %s cur_code cyc=%0d got=%0d exp=%0d", tag, j, o_cur, exp_cur);
            end
            vectors++;
            if (o_bk !== exp_bk) begin
                errors++; $display("FAIL %s bk cyc=%0d got=%h exp=%h", tag, j, o_bk, exp_bk);
            end
            vectors++;
            if ((o_bk & (o_bk + 64'd1)) !== 64'd0) begin
                errors++; $display("FAIL %s bk_thermometer cyc=%0d got=%h exp=thermometer", tag, j, o_bk);
            end
            vectors++;
            if (o_done !== (j == d)) begin
                errors++; $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, j, o_done, (j == d));
            end
            vectors++;
            if (o_busy !== (j <= d)) begin
                errors++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, j, o_busy, (j <= d));
            end
            vectors++;
            if (o_rdy !== (j > d)) begin
                errors++; $display("FAIL %s code_rdy cyc=%0d got=%b exp=%b", tag, j, o_rdy, (j > d));
            end
            if (hold && j <= d) drive(9, 1'b1);
            else drive(0, 1'b0);
            if (j <= d) begin
                @(posedge clk); #1;
            end
        end
        model_cur[which] = t;
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        code_a = '0; code_b = '0; vld_a = 1'b0; vld_b = 1'b0;
        sel = 0;
        model_cur[0] = 0; model_cur[1] = 0;
        #2;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #1;
            vectors++;
            if (o_bk !== 64'd0 || o_cur !== 7'd0) begin
                errors++; $display("FAIL reset_state[%0d] bk/cur got=%h/%0d exp=0/0", i, o_bk, o_cur);
            end
            vectors++;
            if (o_rdy !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                errors++; $display("FAIL reset_state[%0d] rdy/busy/done got=%b%b%b exp=100", i, o_rdy, o_busy, o_done);
            end
        end
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_ramp;
        sel = 0;
        drive(10, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        vectors++;
        if (o_cur !== 7'd3 || o_bk !== 64'h7) begin
            errors++; $display("FAIL mid_ramp_pre cur/bk got=%0d/%h exp=3/7", o_cur, o_bk);
        end
        #2;
        rst_a = 1'b1;
        #1;
        vectors++;
        if (o_bk !== 64'd0 || o_cur !== 7'd0) begin
            errors++; $display("FAIL mid_ramp_reset bk/cur got=%h/%0d exp=0/0", o_bk, o_cur);
        end
        vectors++;
        if (o_rdy !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL mid_ramp_reset rdy/busy/done got=%b%b%b exp=100", o_rdy, o_busy, o_done);
        end
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (o_cur !== 7'd0 || o_busy !== 1'b0 || o_rdy !== 1'b1) begin
            errors++; $display("FAIL after_reset_idle cur/busy/rdy got=%0d/%b/%b exp=0/0/1", o_cur, o_busy, o_rdy);
        end
        model_cur[0] = 0;
    endtask

    task automatic test_ramp_up;
        run_req(0, 5, 1'b0, "ramp_up");
        vectors++;
        if (o_bk !== 64'h1F) begin
            errors++; $display("FAIL ramp_up_final bk got=%h exp=1f", o_bk);
        end
    endtask

    task automatic test_ramp_down;
        run_req(0, 2, 1'b0, "ramp_down");
        vectors++;
        if (o_bk !== 64'h3) begin
            errors++; $display("FAIL ramp_down_final bk got=%h exp=3", o_bk);
        end
    endtask

    task automatic test_noop;
        run_req(0, 2, 1'b0, "noop");
    endtask

    task automatic test_busy_ignored;
        run_req(0, 12, 1'b1, "busy_ignored");
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (o_cur !== 7'd12 || o_busy !== 1'b0) begin
            errors++; $display("FAIL busy_ignored_after cur/busy got=%0d/%b exp=12/0", o_cur, o_busy);
        end
    endtask

    task automatic test_saturation;
        run_req(1, 100, 1'b0, "saturation");
        vectors++;
        if (o_bk !== {64{1'b1}} || o_cur !== 7'd64) begin
            errors++; $display("FAIL saturation_final bk/cur got=%h/%0d exp=all-ones/64", o_bk, o_cur);
        end
        run_req(1, 127, 1'b0, "saturation_hold");
        run_req(1, 0, 1'b0, "ramp_to_zero");
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) run_req(0, int'($urandom_range(0, 127)), 1'b0, "random_a");
        for (int i = 0; i < 8; i++) run_req(1, int'($urandom_range(0, 127)), 1'b0, "random_b");
    endtask

    task automatic test_back_to_back;
        run_req(0, 64, 1'b0, "b2b_1");
        run_req(0, 63, 1'b0, "b2b_2");
        run_req(0, 63, 1'b0, "b2b_3");
        run_req(0, 61, 1'b0, "b2b_4");
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_reset_mid_ramp();
        test_ramp_up();
        test_ramp_down();
        test_noop();
        test_busy_ignored();
        test_saturation();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
